// File: rtl/kyogenrv_rst_seq_if.sv
// kyogenrv_rst_seq_if: reset-request inputs and sequenced domain-reset outputs of the reset sequencer
interface kyogenrv_rst_seq_if #(
  parameter int N_DOM = 3
);
  logic             pll_locked;
  logic             ext_rst_n;
  logic             sw_rst_req;
  logic             wdt_expire;
  logic             cause_clr;
  logic [N_DOM-1:0] dom_rst_n;
  logic             seq_done;
  logic [3:0]       rst_cause;
  modport master (
    output pll_locked, ext_rst_n, sw_rst_req, wdt_expire, cause_clr,
    input  dom_rst_n, seq_done, rst_cause
  );
  modport slave (
    input  pll_locked, ext_rst_n, sw_rst_req, wdt_expire, cause_clr,
    output dom_rst_n, seq_done, rst_cause
  );
endinterface

// File: rtl/kyogenrv_rst_seq.sv
// kyogenrv_rst_seq: synchronises/debounces reset sources and releases N_DOM domain resets in staggered order
module kyogenrv_rst_seq #(
  parameter int N_DOM        = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int HOLD_CYC     = 16,
  parameter int STAGGER_CYC  = 8,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic reset,
  kyogenrv_rst_seq_if.slave bus
);
  localparam int IDX_W = N_DOM > 1 ? $clog2(N_DOM) : 1;
  typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;
  state_t           state;
  logic [SYNC_STAGES-1:0] pll_sync, ext_sync;
  logic [CNT_W-1:0] deb_cnt, cnt;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [N_DOM-1:0] dom_rst_n;
  logic             seq_done;
  logic [3:0]       rst_cause, trig;
  logic             pll_s, ext_s, ext_req, pll_req, any;
  assign pll_s   = pll_sync[SYNC_STAGES-1];
  assign ext_s   = ext_sync[SYNC_STAGES-1];
  assign ext_req = deb_cnt == CNT_W'(DEBOUNCE_CYC);
  assign pll_req = ~pll_s;
  assign trig    = {bus.wdt_expire, bus.sw_rst_req, ext_req, pll_req};
  assign any     = |trig;
  assign nxt_idx = idx + IDX_W'(1);
  assign bus.dom_rst_n = dom_rst_n;
  assign bus.seq_done  = seq_done;
  assign bus.rst_cause = rst_cause;
  always_ff @(posedge clk) begin
    if (reset) begin
      pll_sync <= '0;
      ext_sync <= '0;
      deb_cnt  <= '0;
    end else begin
      pll_sync <= {pll_sync[SYNC_STAGES-2:0], bus.pll_locked};
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], bus.ext_rst_n};
      deb_cnt  <= ext_s ? '0 : ext_req ? deb_cnt : deb_cnt + CNT_W'(1);
    end
  end
  // power-up counts as a pll cause so software always sees a non-zero cause after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASSERT;
      dom_rst_n <= '0;
      seq_done  <= 1'b0;
      rst_cause <= 4'b0001;
      cnt       <= '0;
      idx       <= '0;
    end else begin
      if (any) rst_cause <= state == RUN ? trig : rst_cause | trig;
      else if (bus.cause_clr) rst_cause <= 4'b0000;
      if (any) begin
        state     <= ASSERT;
        dom_rst_n <= '0;
        seq_done  <= 1'b0;
        cnt       <= '0;
        idx       <= '0;
      end else begin
        case (state)
          ASSERT: begin
            cnt <= '0;
            if (pll_s && ext_s) state <= HOLD;
          end
          HOLD: begin
            if (cnt == CNT_W'(HOLD_CYC - 1)) begin
              cnt          <= '0;
              idx          <= '0;
              dom_rst_n[0] <= 1'b1;
              if (N_DOM == 1) begin
                seq_done <= 1'b1;
                state    <= RUN;
              end else state <= RELEASE;
            end else cnt <= cnt + CNT_W'(1);
          end
          RELEASE: begin
            if (cnt == CNT_W'(STAGGER_CYC - 1)) begin
              cnt                <= '0;
              idx                <= nxt_idx;
              dom_rst_n[nxt_idx] <= 1'b1;
              if (nxt_idx == IDX_W'(N_DOM - 1)) begin
                seq_done <= 1'b1;
                state    <= RUN;
              end
            end else cnt <= cnt + CNT_W'(1);
          end
          default: cnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_kyogenrv_rst_seq.sv
// tb_kyogenrv_rst_seq: directed scenarios with hand-computed release timing and cause values
module tb_kyogenrv_rst_seq;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  kyogenrv_rst_seq_if #(.N_DOM(3)) bus ();
  kyogenrv_rst_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_sequence(input int lead, input string tag);
    tick(lead + 15);
    total++;
    if (bus.dom_rst_n !== 3'b000) $display("FAIL %s_h15 dom_rst_n=%b expected 000", tag, bus.dom_rst_n);
    else passed++;
    tick(1);
    total++;
    if (bus.dom_rst_n !== 3'b001) $display("FAIL %s_h16 dom_rst_n=%b expected 001", tag, bus.dom_rst_n);
    else passed++;
    tick(7);
    total++;
    if (bus.dom_rst_n !== 3'b001) $display("FAIL %s_h23 dom_rst_n=%b expected 001", tag, bus.dom_rst_n);
    else passed++;
    tick(1);
    total++;
    if (bus.dom_rst_n !== 3'b011) $display("FAIL %s_h24 dom_rst_n=%b expected 011", tag, bus.dom_rst_n);
    else passed++;
    tick(7);
    total++;
    if (bus.dom_rst_n !== 3'b011 || bus.seq_done !== 1'b0)
      $display("FAIL %s_h31 dom_rst_n=%b seq_done=%b expected 011/0", tag, bus.dom_rst_n, bus.seq_done);
    else passed++;
    tick(1);
    total++;
    if (bus.dom_rst_n !== 3'b111 || bus.seq_done !== 1'b1)
      $display("FAIL %s_h32 dom_rst_n=%b seq_done=%b expected 111/1", tag, bus.dom_rst_n, bus.seq_done);
    else passed++;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.pll_locked = 1'b0;
    bus.ext_rst_n  = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.wdt_expire = 1'b0;
    bus.cause_clr  = 1'b0;
    tick(2);
    total++;
    if (bus.dom_rst_n !== 3'b000 || bus.seq_done !== 1'b0 || bus.rst_cause !== 4'b0001)
      $display("FAIL reset_state dom=%b done=%b cause=%b expected 000/0/0001", bus.dom_rst_n, bus.seq_done, bus.rst_cause);
    else passed++;
    reset = 1'b0;
    bus.pll_locked = 1'b1;
    bus.ext_rst_n  = 1'b1;
    test_sequence(3, "powerup");
    total++;
    if (bus.rst_cause !== 4'b0001) $display("FAIL powerup_cause rst_cause=%b expected 0001", bus.rst_cause);
    else passed++;
  endtask
  task automatic test_debounce;
    bus.ext_rst_n = 1'b0;
    tick(1023);
    bus.ext_rst_n = 1'b1;
    tick(6);
    total++;
    if (bus.dom_rst_n !== 3'b111 || bus.seq_done !== 1'b1 || bus.rst_cause !== 4'b0001)
      $display("FAIL debounce_1023 dom=%b done=%b cause=%b expected 111/1/0001", bus.dom_rst_n, bus.seq_done, bus.rst_cause);
    else passed++;
    bus.ext_rst_n = 1'b0;
    tick(1024);
    bus.ext_rst_n = 1'b1;
    tick(2);
    total++;
    if (bus.dom_rst_n !== 3'b111) $display("FAIL debounce_pre dom_rst_n=%b expected 111", bus.dom_rst_n);
    else passed++;
    tick(1);
    total++;
    if (bus.dom_rst_n !== 3'b000 || bus.seq_done !== 1'b0 || bus.rst_cause !== 4'b0010)
      $display("FAIL debounce_1024 dom=%b done=%b cause=%b expected 000/0/0010", bus.dom_rst_n, bus.seq_done, bus.rst_cause);
    else passed++;
    test_sequence(1, "ext");
  endtask
  task automatic test_sw;
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    total++;
    if (bus.dom_rst_n !== 3'b000 || bus.seq_done !== 1'b0 || bus.rst_cause !== 4'b0100)
      $display("FAIL sw_assert dom=%b done=%b cause=%b expected 000/0/0100", bus.dom_rst_n, bus.seq_done, bus.rst_cause);
    else passed++;
    test_sequence(1, "sw");
  endtask
  task automatic test_wdt_mid_release;
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(21);
    total++;
    if (bus.dom_rst_n !== 3'b001) $display("FAIL wdt_pre dom_rst_n=%b expected 001", bus.dom_rst_n);
    else passed++;
    bus.wdt_expire = 1'b1;
    tick(1);
    bus.wdt_expire = 1'b0;
    total++;
    if (bus.dom_rst_n !== 3'b000 || bus.seq_done !== 1'b0 || bus.rst_cause !== 4'b1100)
      $display("FAIL wdt_assert dom=%b done=%b cause=%b expected 000/0/1100", bus.dom_rst_n, bus.seq_done, bus.rst_cause);
    else passed++;
    test_sequence(1, "wdt");
    total++;
    if (bus.rst_cause !== 4'b1100) $display("FAIL wdt_cause_kept rst_cause=%b expected 1100", bus.rst_cause);
    else passed++;
  endtask
  task automatic test_pll_drop_and_clr;
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(6);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(1);
    total++;
    if (bus.rst_cause !== 4'b0100) $display("FAIL pll_drop_pre rst_cause=%b expected 0100", bus.rst_cause);
    else passed++;
    tick(1);
    total++;
    if (bus.rst_cause !== 4'b0101 || bus.dom_rst_n !== 3'b000)
      $display("FAIL pll_drop cause=%b dom=%b expected 0101/000", bus.rst_cause, bus.dom_rst_n);
    else passed++;
    test_sequence(1, "pll");
    bus.sw_rst_req = 1'b1;
    bus.cause_clr  = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    total++;
    if (bus.rst_cause !== 4'b0100 || bus.dom_rst_n !== 3'b000)
      $display("FAIL clr_vs_trig cause=%b dom=%b expected 0100/000", bus.rst_cause, bus.dom_rst_n);
    else passed++;
    tick(1);
    bus.cause_clr = 1'b0;
    total++;
    if (bus.rst_cause !== 4'b0000) $display("FAIL clr_alone rst_cause=%b expected 0000", bus.rst_cause);
    else passed++;
    test_sequence(0, "clr");
  endtask
  task automatic test_reset_mid_release;
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
    tick(27);
    total++;
    if (bus.dom_rst_n !== 3'b011) $display("FAIL rst_mid_pre dom_rst_n=%b expected 011", bus.dom_rst_n);
    else passed++;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    total++;
    if (bus.dom_rst_n !== 3'b000 || bus.seq_done !== 1'b0 || bus.rst_cause !== 4'b0001)
      $display("FAIL rst_mid dom=%b done=%b cause=%b expected 000/0/0001", bus.dom_rst_n, bus.seq_done, bus.rst_cause);
    else passed++;
    test_sequence(3, "rst");
    total++;
    if (bus.rst_cause !== 4'b0001) $display("FAIL rst_cause_end rst_cause=%b expected 0001", bus.rst_cause);
    else passed++;
  endtask
  initial begin
    test_reset;
    test_debounce;
    test_sw;
    test_wdt_mid_release;
    test_pll_drop_and_clr;
    test_reset_mid_release;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
